// File: rtl/jtkcpu_stack_pkg.sv
// Shared definitions for the KCPU stack push/pull engine: FSM states,
// register-file select codes, mask bit positions and forced-mask helpers.
package jtkcpu_stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_PULL,
    ST_RTICHK,
    ST_DONE
  } stk_state_t;

  // Register-file select codes; they double as the mask bit positions
  localparam logic [2:0] REG_CC = 3'd0;
  localparam logic [2:0] REG_A  = 3'd1;
  localparam logic [2:0] REG_B  = 3'd2;
  localparam logic [2:0] REG_DP = 3'd3;
  localparam logic [2:0] REG_X  = 3'd4;
  localparam logic [2:0] REG_Y  = 3'd5;
  localparam logic [2:0] REG_US = 3'd6;
  localparam logic [2:0] REG_PC = 3'd7;

  localparam logic [7:0] MASK_ALL    = 8'hFF;
  localparam logic [7:0] MASK_RTI_E  = 8'hFE;
  localparam logic [7:0] MASK_RTI_PC = 8'h80;

  // X, Y, U/S and PC are 16-bit; CC, A, B and DP are 8-bit
  function automatic logic is_word(input logic [2:0] idx);
    return idx >= REG_X;
  endfunction

  function automatic logic [7:0] request_mask(input logic       all,
                                              input logic       cc,
                                              input logic       pc,
                                              input logic [7:0] postbyte);
    if (all)
      return MASK_ALL;
    else if (cc || pc)
      return {pc, 6'b0, cc};
    else
      return postbyte;
  endfunction

endpackage

// File: rtl/jtkcpu_stack_if.sv
// Request, bus and register-file signals between the ucode/bus side (master)
// and the stack engine (slave).
interface jtkcpu_stack_if #(
  parameter int AW = 16
);
  import jtkcpu_stack_pkg::*;

  logic          psh_go;
  logic          pul_go;
  logic          pshall;
  logic          pshcc;
  logic          pshpc;
  logic          rti_cc;
  logic          use_u;
  logic [7:0]    postbyte;
  logic [AW-1:0] sp_in;
  logic          mem_busy;
  logic [7:0]    din;
  logic [7:0]    reg_dout;

  logic [AW-1:0] addr;
  logic [7:0]    dout;
  logic          we;
  logic [2:0]    reg_sel;
  logic          reg_hi;
  logic          reg_we;
  logic [AW-1:0] sp_out;
  logic          sp_we;
  logic          busy;
  logic          done;

  modport master (
    output psh_go, pul_go, pshall, pshcc, pshpc, rti_cc, use_u, postbyte,
           sp_in, mem_busy, din, reg_dout,
    input  addr, dout, we, reg_sel, reg_hi, reg_we, sp_out, sp_we, busy, done
  );

  modport slave (
    input  psh_go, pul_go, pshall, pshcc, pshpc, rti_cc, use_u, postbyte,
           sp_in, mem_busy, din, reg_dout,
    output addr, dout, we, reg_sel, reg_hi, reg_we, sp_out, sp_we, busy, done
  );

endinterface

// File: rtl/jtkcpu_stack_pri.sv
// Priority picker over the stack register mask: msb-first when pushing,
// lsb-first when pulling.
module jtkcpu_stack_pri
  import jtkcpu_stack_pkg::*;
(
  input  logic [7:0] i_mask,
  input  logic       i_msb_first,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  // The last match in scan order wins, so scan towards the wanted end
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    if (i_msb_first) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i_mask[3'(i)]) begin
          o_idx   = 3'(i);
          o_valid = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i_mask[3'(7 - i)]) begin
          o_idx   = 3'(7 - i);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtkcpu_stack.sv
// Stack push/pull engine: walks a register mask one byte per enabled,
// unstalled cycle and returns the updated S/U pointer.
module jtkcpu_stack
  import jtkcpu_stack_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  jtkcpu_stack_if.slave   bus
);

  stk_state_t    r_state, w_state_nx;
  logic [7:0]    r_mask, w_mask_nx;
  logic [AW-1:0] r_sp, w_sp_nx;
  // Set once the first byte of a 16-bit register has been transferred
  logic          r_second, w_second_nx;

  logic [2:0]    w_idx;
  logic          w_valid;
  logic          w_word;
  logic          w_last;
  logic          w_commit;
  logic [7:0]    w_mask_clr;
  logic [7:0]    w_req_mask;

  logic [AW-1:0] w_addr;
  logic [7:0]    w_dout;
  logic          w_we;
  logic          w_reg_we;
  logic [2:0]    w_reg_sel;
  logic          w_reg_hi;
  logic          w_sp_we;
  logic          w_done;

  jtkcpu_stack_pri u_pri (
    .i_mask      (r_mask),
    .i_msb_first (r_state == ST_PUSH),
    .o_idx       (w_idx),
    .o_valid     (w_valid)
  );

  assign w_req_mask = request_mask(bus.pshall, bus.pshcc, bus.pshpc, bus.postbyte);
  assign w_word     = is_word(w_idx);
  assign w_last     = ~w_word | r_second;
  assign w_commit   = cen & ~bus.mem_busy;
  assign w_mask_clr = r_mask & ~(8'b1 << w_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_sp     <= '0;
      r_second <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_mask   <= w_mask_nx;
      r_sp     <= w_sp_nx;
      r_second <= w_second_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_mask_nx   = r_mask;
    w_sp_nx     = r_sp;
    w_second_nx = r_second;
    w_addr      = '0;
    w_dout      = '0;
    w_we        = 1'b0;
    w_reg_we    = 1'b0;
    w_reg_sel   = '0;
    w_reg_hi    = 1'b0;
    w_sp_we     = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cen) begin
          if (bus.psh_go) begin
            w_sp_nx     = bus.sp_in;
            w_mask_nx   = w_req_mask;
            w_second_nx = 1'b0;
            w_state_nx  = (w_req_mask == '0) ? ST_DONE : ST_PUSH;
          end else if (bus.pul_go) begin
            w_sp_nx     = bus.sp_in;
            w_second_nx = 1'b0;
            if (bus.rti_cc) begin
              w_mask_nx  = '0;
              w_state_nx = ST_RTICHK;
            end else begin
              w_mask_nx  = w_req_mask;
              w_state_nx = (w_req_mask == '0) ? ST_DONE : ST_PULL;
            end
          end
        end
      end

      // Pre-decrement; a word goes out low byte first so it lands big-endian
      ST_PUSH: begin
        if (!w_valid) begin
          if (cen) w_state_nx = ST_DONE;
        end else begin
          w_addr    = r_sp - AW'(1);
          w_we      = 1'b1;
          w_dout    = bus.reg_dout;
          w_reg_sel = w_idx;
          w_reg_hi  = w_word & r_second;
          if (w_commit) begin
            w_sp_nx = r_sp - AW'(1);
            if (w_last) begin
              w_mask_nx   = w_mask_clr;
              w_second_nx = 1'b0;
              if (w_mask_clr == '0) w_state_nx = ST_DONE;
            end else begin
              w_second_nx = 1'b1;
            end
          end
        end
      end

      ST_PULL: begin
        if (!w_valid) begin
          if (cen) w_state_nx = ST_DONE;
        end else begin
          w_addr    = r_sp;
          w_reg_we  = 1'b1;
          w_reg_sel = w_idx;
          w_reg_hi  = w_word & ~r_second;
          if (w_commit) begin
            w_sp_nx = r_sp + AW'(1);
            if (w_last) begin
              w_mask_nx   = w_mask_clr;
              w_second_nx = 1'b0;
              if (w_mask_clr == '0) w_state_nx = ST_DONE;
            end else begin
              w_second_nx = 1'b1;
            end
          end
        end
      end

      // CC comes back first; its E bit decides between a full or PC-only frame
      ST_RTICHK: begin
        w_addr    = r_sp;
        w_reg_we  = 1'b1;
        w_reg_sel = REG_CC;
        if (w_commit) begin
          w_sp_nx    = r_sp + AW'(1);
          w_mask_nx  = bus.din[7] ? MASK_RTI_E : MASK_RTI_PC;
          w_state_nx = ST_PULL;
        end
      end

      ST_DONE: begin
        w_sp_we = 1'b1;
        w_done  = 1'b1;
        if (cen) w_state_nx = ST_IDLE;
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign bus.addr    = w_addr;
  assign bus.dout    = w_dout;
  assign bus.we      = w_we;
  assign bus.reg_we  = w_reg_we;
  assign bus.reg_sel = w_reg_sel;
  assign bus.reg_hi  = w_reg_hi;
  assign bus.sp_out  = r_sp;
  assign bus.sp_we   = w_sp_we;
  assign bus.done    = w_done;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule
